// File: rtl/axi4_gpio_regs_if.sv
// AXI4 bus bundle used by the GPIO register block and its bench.
//
// Handshake rule for all five channels: a transfer happens on the rising clk
// edge where VALID and READY are both 1. The sender holds VALID and its payload
// stable until that edge. VALID never waits on READY. READY may depend
// combinationally on VALID or state.
interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 5
);
    // Write address channel
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    // Write data channel
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    // Write response channel
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    // Read address channel
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    // Read data channel
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_gpio_regs.sv
// AXI4 slave GPIO register block.
// Map (beat address [11:2]): 0x0 OUT (RW), 0x4 IN (RO), 0x8 IRQ_EN (RW),
// 0xC IRQ_STAT (W1C). Other offsets answer SLVERR. Every burst is INCR with
// 4-byte beats. Read and write channels are independent FSMs.
module axi4_gpio_regs #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 5,
    parameter int N_OUT              = 4,
    parameter int N_IN               = 4,
    parameter int SYNC_STAGES        = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    axi4_if.slave            s,
    output logic [N_OUT-1:0] gpio_o,
    input  logic [N_IN-1:0]  gpio_i,
    output logic             irq_o
);

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_DATA = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Address taps. Only the word index inside the 4 KiB window is decoded;
    // the interconnect has already selected this slave.
    // ------------------------------------------------------------------
    logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_w;
    logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_w;

    assign ar_addr_w = s.araddr;
    assign aw_addr_w = s.awaddr;

    // Burst type, size and AWLEN are deliberately ignored.
    logic unused_ok;
    assign unused_ok = ^{s.awlen, s.awsize, s.awburst, s.arsize, s.arburst,
                         ar_addr_w[AXI4_ADDRESS_WIDTH-1:12], ar_addr_w[1:0],
                         aw_addr_w[AXI4_ADDRESS_WIDTH-1:12], aw_addr_w[1:0],
                         s.wdata, s.wstrb};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [N_OUT-1:0] out_q,      out_d;
    logic [N_IN-1:0]  irq_en_q,   irq_en_d;
    logic [N_IN-1:0]  irq_stat_q, irq_stat_d;
    logic [N_IN-1:0]  irq_clr;

    // Input synchroniser chain; the last stage is sync_q, then prev_q.
    logic [N_IN-1:0]  sync_pipe_q [SYNC_STAGES];
    logic [N_IN-1:0]  sync_q;
    logic [N_IN-1:0]  prev_q;
    logic [N_IN-1:0]  rise;

    // Read FSM state
    logic [0:0]               rd_state_q, rd_state_d;
    logic [9:0]               rd_idx_q,   rd_idx_d;
    logic [AXI4_ID_WIDTH-1:0] rd_id_q,    rd_id_d;
    logic [7:0]               rd_len_q,   rd_len_d;
    logic [7:0]               rd_beat_q,  rd_beat_d;
    logic [AXI4_DATA_WIDTH-1:0] rd_data;
    logic [1:0]               rd_resp;

    // Write FSM state
    logic [1:0]               wr_state_q, wr_state_d;
    logic [9:0]               wr_idx_q,   wr_idx_d;
    logic [AXI4_ID_WIDTH-1:0] wr_id_q,    wr_id_d;
    logic                     wr_err_q,   wr_err_d;
    logic                     wr_fire;
    logic                     wr_mapped;

    // ------------------------------------------------------------------
    // Input synchroniser: SYNC_STAGES flops, then one more for edge detect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_pipe_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_pipe_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe_q[i] <= sync_pipe_q[i-1];
            end
            prev_q <= sync_q;
        end
    end

    assign sync_q = sync_pipe_q[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev_q;

    // ------------------------------------------------------------------
    // Read FSM next state: accept AR in idle, then stream LEN+1 beats.
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_id_d    = rd_id_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (s.arvalid) begin
                    rd_idx_d   = ar_addr_w[11:2];
                    rd_id_d    = s.arid;
                    rd_len_d   = s.arlen;
                    rd_beat_d  = 8'd0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s.rready) begin
                    if (rd_beat_q == rd_len_q) begin
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_beat_d = rd_beat_q + 8'd1;
                        rd_idx_d  = rd_idx_q + 10'd1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_idx_q   <= '0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
        end
    end

    // Read mux: sampled from the register outputs, so a same-cycle write is
    // not yet visible and the read returns the old value.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx_q)
            10'd0: for (int b = 0; b < N_OUT; b++) rd_data[b] = out_q[b];
            10'd1: for (int b = 0; b < N_IN; b++)  rd_data[b] = sync_q[b];
            10'd2: for (int b = 0; b < N_IN; b++)  rd_data[b] = irq_en_q[b];
            10'd3: for (int b = 0; b < N_IN; b++)  rd_data[b] = irq_stat_q[b];
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    // Ready/valid are forced low while reset is held.
    assign s.arready = rst_n && (rd_state_q == RD_IDLE);
    assign s.rvalid  = rst_n && (rd_state_q == RD_DATA);
    assign s.rid     = rd_id_q;
    assign s.rdata   = rd_data;
    assign s.rresp   = rd_resp;
    assign s.rlast   = (rd_beat_q == rd_len_q);

    // ------------------------------------------------------------------
    // Write FSM next state: AW, then W beats until WLAST, then B.
    // ------------------------------------------------------------------
    assign wr_fire   = (wr_state_q == WR_DATA) && s.wvalid;
    assign wr_mapped = (wr_idx_q < 10'd4);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_id_d    = wr_id_q;
        wr_err_d   = wr_err_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (s.awvalid) begin
                    wr_idx_d   = aw_addr_w[11:2];
                    wr_id_d    = s.awid;
                    wr_err_d   = 1'b0;
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (s.wvalid) begin
                    if (!wr_mapped) begin
                        wr_err_d = 1'b1;
                    end
                    wr_idx_d = wr_idx_q + 10'd1;
                    if (s.wlast) begin
                        wr_state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (s.bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_idx_q   <= '0;
            wr_id_q    <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_id_q    <= wr_id_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign s.awready = rst_n && (wr_state_q == WR_IDLE);
    assign s.wready  = rst_n && (wr_state_q == WR_DATA);
    assign s.bvalid  = rst_n && (wr_state_q == WR_RESP);
    assign s.bid     = wr_id_q;
    assign s.bresp   = wr_err_q ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Register write decode with byte-lane enables. Bit b lives in lane b/8.
    // An edge on a bit being cleared in the same cycle keeps the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        irq_clr  = '0;
        if (wr_fire) begin
            case (wr_idx_q)
                10'd0: begin
                    for (int b = 0; b < N_OUT; b++) begin
                        if (s.wstrb[b/8]) out_d[b] = s.wdata[b];
                    end
                end
                10'd2: begin
                    for (int b = 0; b < N_IN; b++) begin
                        if (s.wstrb[b/8]) irq_en_d[b] = s.wdata[b];
                    end
                end
                10'd3: begin
                    for (int b = 0; b < N_IN; b++) begin
                        if (s.wstrb[b/8] && s.wdata[b]) irq_clr[b] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        irq_stat_d = (irq_stat_q & ~irq_clr) | rise;
    end

    // Register file update.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
        end else begin
            out_q      <= out_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
        end
    end

    assign gpio_o = out_q;
    assign irq_o  = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_axi4_gpio_regs.sv
// Bench for axi4_gpio_regs: directed steps plus a randomized phase, all
// checked against a register-level reference model.
module tb_axi4_gpio_regs;

  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_n;
  logic [3:0] gpio_i;
  logic [3:0] gpio_o;
  logic       irq_o;

  axi4_if #(.ADDR_W(32), .DATA_W(32), .ID_W(5)) bus ();

  axi4_gpio_regs #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(5),
    .N_OUT(4), .N_IN(4), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .s     (bus),
    .gpio_o(gpio_o),
    .gpio_i(gpio_i),
    .irq_o (irq_o)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  logic [31:0] m_out, m_en, m_stat, m_in;
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [3:0]  beat_gpio;
  logic        beat_irq;
  logic [4:0]  bid;
  logic [1:0]  bresp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Model of a single register read at word index idx.
  task automatic model_read(input logic [9:0] idx, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    case (idx)
      10'd0:   d = m_out;
      10'd1:   d = m_in;
      10'd2:   d = m_en;
      10'd3:   d = m_stat;
      default: begin d = 32'h0; r = 2'b10; end
    endcase
  endtask

  // Model of one write beat; returns 1 when the offset is unmapped.
  function automatic bit model_write(input logic [9:0] idx, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] bm;
    bm = lane_mask(strb);
    case (idx)
      10'd0:   m_out  = ((m_out & ~bm) | (d & bm)) & 32'hF;
      10'd1:   ;
      10'd2:   m_en   = ((m_en & ~bm) | (d & bm)) & 32'hF;
      10'd3:   m_stat = m_stat & ~(d & bm);
      default: return 1'b1;
    endcase
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pins settle past the synchroniser; rising bits land in IRQ_STAT.
  task automatic set_gpio(input logic [3:0] v);
    logic [31:0] old;
    old = m_in;
    gpio_i = v;
    repeat (SYNC + 2) tick();
    m_stat = m_stat | ({28'h0, v} & ~old);
    m_in   = {28'h0, v};
  endtask

  // Burst write of the beats in wq_data/wq_strb; w_delay idle cycles before W.
  task automatic axi_write(input logic [31:0] addr, input logic [4:0] id, input int w_delay);
    int n;
    int cnt;
    n = wq_data.size();
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awid    = id;
    bus.awlen   = 8'(n - 1);
    bus.awsize  = 3'd2;
    bus.awburst = 2'($urandom_range(0, 3));
    cnt = 0;
    while (bus.awready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    if (cnt == 50) timeout("aw_handshake");
    tick();
    bus.awvalid = 1'b0;
    repeat (w_delay) tick();
    for (int b = 0; b < n; b++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = wq_data[b];
      bus.wstrb  = wq_strb[b];
      bus.wlast  = (b == n - 1);
      cnt = 0;
      while (bus.wready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
      if (cnt == 50) timeout("w_handshake");
      tick();
      beat_gpio = gpio_o;
      beat_irq  = irq_o;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    cnt = 0;
    while (bus.bvalid !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    if (cnt == 50) timeout("b_handshake");
    bid   = bus.bid;
    bresp = bus.bresp;
    tick();
    bus.bready = 1'b0;
    wq_data.delete();
    wq_strb.delete();
  endtask

  // Burst read checked beat by beat against the model; optional RREADY stalls.
  task automatic axi_read(input logic [31:0] addr, input logic [4:0] id, input logic [7:0] len,
                          input bit stall);
    int cnt;
    int got;
    logic [31:0] ed;
    logic [1:0]  er;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arid    = id;
    bus.arlen   = len;
    bus.arsize  = 3'd2;
    bus.arburst = 2'($urandom_range(0, 3));
    cnt = 0;
    while (bus.arready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    if (cnt == 50) timeout("ar_handshake");
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
    got = 0;
    cnt = 0;
    while (got <= int'(len) && cnt < 400) begin
      model_read(10'(addr[11:2] + 10'(got)), ed, er);
      if (stall && $urandom_range(0, 1) == 1) begin
        bus.rready = 1'b0;
        tick();
        chk("stall_rvalid", 32'(bus.rvalid), 32'd1);
        chk("stall_rdata", bus.rdata, ed);
        chk("stall_rlast", 32'(bus.rlast), 32'(got == int'(len)));
      end else begin
        bus.rready = 1'b1;
        chk("rdata", bus.rdata, ed);
        chk("rresp", 32'(bus.rresp), 32'(er));
        chk("rid", 32'(bus.rid), 32'(id));
        chk("rlast", 32'(bus.rlast), 32'(got == int'(len)));
        tick();
        got++;
      end
      cnt++;
    end
    if (cnt == 400) timeout("r_beats");
    bus.rready = 1'b0;
    chk("rvalid_done", 32'(bus.rvalid), 32'd0);
  endtask

  // Random write burst, compared against the model's response and OUT pins.
  task automatic rand_write();
    int n;
    logic [9:0] idx;
    logic [4:0] id;
    bit err;
    n   = $urandom_range(1, 3);
    idx = 10'($urandom_range(0, 5));
    id  = 5'($urandom_range(0, 31));
    err = 1'b0;
    for (int b = 0; b < n; b++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(4'($urandom_range(0, 15)));
      if (model_write(10'(idx + 10'(b)), wq_data[b], wq_strb[b])) err = 1'b1;
    end
    axi_write({20'h0, idx, 2'b00}, id, $urandom_range(0, 2));
    chk("rw_bid", 32'(bid), 32'(id));
    chk("rw_bresp", 32'(bresp), err ? 32'd2 : 32'd0);
    chk("rw_gpio", 32'(gpio_o), m_out);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    gpio_i = 4'h0;
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    m_out = 0; m_en = 0; m_stat = 0; m_in = 0;

    // T1 reset
    repeat (3) tick();
    chk("rst_gpio_o", 32'(gpio_o), 32'd0);
    chk("rst_irq_o", 32'(irq_o), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_arready", 32'(bus.arready), 32'd1);
    chk("post_rst_awready", 32'(bus.awready), 32'd1);

    // T2 OUT write, then an all-lanes-disabled write
    wq_data.push_back(32'h5); wq_strb.push_back(4'hF);
    void'(model_write(10'd0, 32'h5, 4'hF));
    axi_write(32'h0, 5'd3, 0);
    chk("t2_gpio_after_beat", 32'(beat_gpio), 32'h5);
    chk("t2_bid", 32'(bid), 32'd3);
    chk("t2_bresp", 32'(bresp), 32'd0);
    wq_data.push_back(32'hA); wq_strb.push_back(4'h0);
    void'(model_write(10'd0, 32'hA, 4'h0));
    axi_write(32'h0, 5'd4, 1);
    chk("t2_strb0_gpio", 32'(beat_gpio), 32'h5);
    chk("t2_strb0_bresp", 32'(bresp), 32'd0);

    // T3 4-beat read burst across the map with RREADY stalls
    set_gpio(4'($urandom_range(0, 15)));
    wq_data.push_back($urandom); wq_strb.push_back(4'hF);
    void'(model_write(10'd2, wq_data[0], 4'hF));
    axi_write(32'h8, 5'd1, 0);
    axi_read(32'h0, 5'd7, 8'd3, 1'b1);

    // T4 rising edge interrupt, W1C, and edge coincident with W1C
    set_gpio(4'h0);
    wq_data.push_back(32'hF); wq_strb.push_back(4'hF);
    void'(model_write(10'd3, 32'hF, 4'hF));
    axi_write(32'hC, 5'd2, 0);
    wq_data.push_back(32'h4); wq_strb.push_back(4'hF);
    void'(model_write(10'd2, 32'h4, 4'hF));
    axi_write(32'h8, 5'd2, 0);
    chk("t4_irq_idle", 32'(irq_o), 32'd0);
    gpio_i = 4'h4;
    repeat (SYNC) tick();
    chk("t4_irq_before", 32'(irq_o), 32'd0);
    tick();
    chk("t4_irq_after", 32'(irq_o), 32'd1);
    m_stat = m_stat | 32'h4;
    m_in   = 32'h4;
    axi_read(32'hC, 5'd9, 8'd0, 1'b0);
    wq_data.push_back(32'h4); wq_strb.push_back(4'hF);
    void'(model_write(10'd3, 32'h4, 4'hF));
    axi_write(32'hC, 5'd5, 0);
    chk("t4_w1c_irq", 32'(beat_irq), 32'd0);
    set_gpio(4'h0);
    wq_data.push_back(32'h4); wq_strb.push_back(4'hF);
    fork
      begin
        tick();
        gpio_i = 4'h4;
      end
      axi_write(32'hC, 5'd6, SYNC);
    join
    void'(model_write(10'd3, 32'h4, 4'hF));
    m_stat = m_stat | 32'h4;
    m_in   = 32'h4;
    chk("t4_set_wins_irq", 32'(beat_irq), 32'd1);
    axi_read(32'hC, 5'd10, 8'd0, 1'b0);

    // T5 unmapped offsets
    wq_data.push_back(32'hFFFF_FFFF); wq_strb.push_back(4'hF);
    axi_write(32'h10, 5'd11, 0);
    chk("t5_unmapped_bresp", 32'(bresp), 32'd2);
    axi_read(32'h0, 5'd12, 8'd3, 1'b0);
    axi_read(32'h10, 5'd13, 8'd0, 1'b0);
    wq_data.push_back(32'h3); wq_strb.push_back(4'hF);
    wq_data.push_back(32'h0); wq_strb.push_back(4'hF);
    void'(model_write(10'd2, 32'h3, 4'hF));
    void'(model_write(10'd3, 32'h0, 4'hF));
    axi_write(32'h8, 5'd14, 0);
    chk("t5_two_beat_bresp", 32'(bresp), 32'd0);
    wq_data.push_back(32'h4); wq_strb.push_back(4'hF);
    wq_data.push_back(32'h1); wq_strb.push_back(4'hF);
    void'(model_write(10'd3, 32'h4, 4'hF));
    axi_write(32'hC, 5'd15, 0);
    chk("t5_cross_bresp", 32'(bresp), 32'd2);
    axi_read(32'h0, 5'd16, 8'd4, 1'b1);

    // Randomized mix of writes, reads, pin changes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: rand_write();
        1: axi_read({20'h0, 10'($urandom_range(0, 5)), 2'b00}, 5'($urandom_range(0, 31)),
                    8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        default: begin
          set_gpio(4'($urandom_range(0, 15)));
          chk("rand_irq", 32'(irq_o), 32'(|(m_stat & m_en)));
        end
      endcase
    end

    // T6 reset in the middle of a read burst and a write burst
    set_gpio(4'h0);
    bus.arvalid = 1'b1; bus.araddr = 32'h0; bus.arid = 5'd1; bus.arlen = 8'd7;
    tick();
    bus.arvalid = 1'b0;
    chk("t6_rd_started", 32'(bus.rvalid), 32'd1);
    bus.awvalid = 1'b1; bus.awaddr = 32'h0; bus.awid = 5'd2;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h9; bus.wstrb = 4'hF; bus.wlast = 1'b0;
    tick();
    bus.wvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t6_rvalid", 32'(bus.rvalid), 32'd0);
    chk("t6_bvalid", 32'(bus.bvalid), 32'd0);
    chk("t6_gpio_o", 32'(gpio_o), 32'd0);
    rst_n = 1'b1;
    m_out = 0; m_en = 0; m_stat = 0; m_in = 0;
    tick();
    wq_data.push_back(32'h6); wq_strb.push_back(4'h1);
    void'(model_write(10'd0, 32'h6, 4'h1));
    axi_write(32'h0, 5'd17, 0);
    chk("t6_fresh_bresp", 32'(bresp), 32'd0);
    chk("t6_fresh_bid", 32'(bid), 32'd17);
    chk("t6_fresh_gpio", 32'(gpio_o), 32'h6);
    axi_read(32'h0, 5'd18, 8'd3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
